// File: rtl/insn_decode_stage.sv
// Instruction decode stage: classifies and field-extracts instruction words,
// buffers bundles in a two-entry skid, and halts on HLT until resumed.
module insn_decode_stage #(
   parameter int unsigned INSN_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned REG_WIDTH  = 4,
   parameter int unsigned FUNC_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [INSN_WIDTH-1:0] in_insn,
   output logic                  in_ready,
   input  logic                  flush,
   input  logic                  resume,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_is_set,
   output logic                  out_is_branch,
   output logic                  out_is_op,
   output logic [REG_WIDTH-1:0]  out_reg_a,
   output logic [REG_WIDTH-1:0]  out_reg_b,
   output logic [FUNC_WIDTH-1:0] out_func,
   output logic [DATA_WIDTH-1:0] out_immd,
   output logic                  out_cond,
   output logic                  out_rel,
   output logic                  out_illegal,
   output logic                  halted
);

   localparam int unsigned W = INSN_WIDTH;
   localparam logic [FUNC_WIDTH-1:0] FUNC_MAX = {1'b1, {(FUNC_WIDTH-1){1'b0}}};

   typedef struct packed {
      logic                  is_set;
      logic                  is_branch;
      logic                  is_op;
      logic [REG_WIDTH-1:0]  reg_a;
      logic [REG_WIDTH-1:0]  reg_b;
      logic [FUNC_WIDTH-1:0] func;
      logic [DATA_WIDTH-1:0] immd;
      logic                  cond;
      logic                  rel;
      logic                  illegal;
   } bundle_t;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t  state, state_nx;
   logic    alive;
   logic    out_v, out_v_nx, skid_v, skid_v_nx;
   bundle_t out_b, out_b_nx, skid_b, skid_b_nx, dec_b;
   logic    is_hlt, is_nop, accept, push;

   always_comb begin
      dec_b = '0;
      if (in_insn[W-1]) begin
         dec_b.is_set = 1'b1;
         dec_b.reg_a  = in_insn[W-2 -: REG_WIDTH];
         dec_b.immd   = DATA_WIDTH'(in_insn[W-2-REG_WIDTH:0]);
      end else if (in_insn[W-2]) begin
         dec_b.is_branch = 1'b1;
         dec_b.cond      = in_insn[W-3];
         dec_b.rel       = in_insn[W-4];
         if (in_insn[W-4])
            dec_b.immd = {{(DATA_WIDTH-W+4){in_insn[W-5]}}, in_insn[W-5:0]};
         else
            dec_b.immd = DATA_WIDTH'(in_insn[W-5:0]);
      end else if (in_insn[W-3]) begin
         if (in_insn[FUNC_WIDTH-1:0] > FUNC_MAX) begin
            dec_b.illegal = 1'b1;
         end else begin
            dec_b.is_op = 1'b1;
            dec_b.reg_a = in_insn[W-4 -: REG_WIDTH];
            dec_b.reg_b = in_insn[W-4-REG_WIDTH -: REG_WIDTH];
            dec_b.func  = in_insn[FUNC_WIDTH-1:0];
         end
      end else begin
         dec_b.illegal = |in_insn[W-4:1];
      end
   end

   assign is_hlt   = (in_insn == '0);
   assign is_nop   = (in_insn == INSN_WIDTH'(1));
   assign in_ready = alive && (state == RUN) && !skid_v;
   assign accept   = in_valid && in_ready;
   assign push     = accept && !is_hlt && !is_nop && !flush;

   // The skid only fills while the output register is stalled; in_ready
   // guarantees it is empty whenever a new bundle is pushed.
   always_comb begin
      out_v_nx  = out_v;
      out_b_nx  = out_b;
      skid_v_nx = skid_v;
      skid_b_nx = skid_b;
      if (flush) begin
         out_v_nx  = 1'b0;
         skid_v_nx = 1'b0;
      end else if (!out_v || out_ready) begin
         if (skid_v) begin
            out_v_nx  = 1'b1;
            out_b_nx  = skid_b;
            skid_v_nx = 1'b0;
         end else begin
            out_v_nx = push;
            if (push) out_b_nx = dec_b;
         end
      end else if (push) begin
         skid_v_nx = 1'b1;
         skid_b_nx = dec_b;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         RUN:    if (accept && is_hlt && !flush) state_nx = DRAIN;
         DRAIN:  if (flush || (!skid_v && (!out_v || out_ready))) state_nx = HALTED;
         HALTED: if (resume) state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         alive  <= 1'b0;
         out_v  <= 1'b0;
         skid_v <= 1'b0;
         out_b  <= '0;
         skid_b <= '0;
      end else begin
         state  <= state_nx;
         alive  <= 1'b1;
         out_v  <= out_v_nx;
         skid_v <= skid_v_nx;
         out_b  <= out_b_nx;
         skid_b <= skid_b_nx;
      end
   end

   assign out_valid     = out_v;
   assign out_is_set    = out_b.is_set;
   assign out_is_branch = out_b.is_branch;
   assign out_is_op     = out_b.is_op;
   assign out_reg_a     = out_b.reg_a;
   assign out_reg_b     = out_b.reg_b;
   assign out_func      = out_b.func;
   assign out_immd      = out_b.immd;
   assign out_cond      = out_b.cond;
   assign out_rel       = out_b.rel;
   assign out_illegal   = out_b.illegal;
   assign halted        = (state == HALTED);

endmodule
